// File: rtl/axi_arw_merger.sv
// Merges the AXI4 AW and AR address channels into one registered ARW command channel.
// The W channel is forwarded only for bursts whose write command has already been issued.
module axi_arw_merger #(
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 8,
    parameter int DATA_WIDTH     = 128,
    parameter int MAX_WR_PENDING = 4
) (
    input  logic                    axi_clk,
    input  logic                    rstn,

    input  logic                    s_aw_valid,
    output logic                    s_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [ID_WIDTH-1:0]     s_aw_id,
    input  logic [7:0]              s_aw_len,
    input  logic [2:0]              s_aw_size,
    input  logic [1:0]              s_aw_burst,
    input  logic [1:0]              s_aw_lock,

    input  logic                    s_ar_valid,
    output logic                    s_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic [ID_WIDTH-1:0]     s_ar_id,
    input  logic [7:0]              s_ar_len,
    input  logic [2:0]              s_ar_size,
    input  logic [1:0]              s_ar_burst,
    input  logic [1:0]              s_ar_lock,

    input  logic                    s_w_valid,
    output logic                    s_w_ready,
    input  logic [ID_WIDTH-1:0]     s_w_id,
    input  logic [DATA_WIDTH-1:0]   s_w_data,
    input  logic [DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                    s_w_last,

    output logic                    m_arw_valid,
    input  logic                    m_arw_ready,
    output logic [ADDR_WIDTH-1:0]   m_arw_addr,
    output logic [ID_WIDTH-1:0]     m_arw_id,
    output logic [7:0]              m_arw_len,
    output logic [2:0]              m_arw_size,
    output logic [1:0]              m_arw_burst,
    output logic [1:0]              m_arw_lock,
    output logic                    m_arw_write,

    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    output logic [ID_WIDTH-1:0]     m_w_id,
    output logic [DATA_WIDTH-1:0]   m_w_data,
    output logic [DATA_WIDTH/8-1:0] m_w_strb,
    output logic                    m_w_last,

    output logic [3:0]              wr_pending
);

    // Handshakes: a transfer happens on a rising clock edge where valid && ready.
    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    grant_t last_grant;
    logic   load_en;
    logic   wr_ok;
    logic   grant_w;
    logic   grant_r;
    logic   aw_acc;
    logic   ar_acc;
    logic   w_done;
    logic   gate;

    assign load_en = !m_arw_valid || m_arw_ready;
    assign wr_ok   = s_aw_valid && (wr_pending < 4'(MAX_WR_PENDING));

    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (wr_ok && s_ar_valid) begin
            if (last_grant == GRANT_READ) grant_w = 1'b1;
            else                          grant_r = 1'b1;
        end else if (wr_ok) begin
            grant_w = 1'b1;
        end else if (s_ar_valid) begin
            grant_r = 1'b1;
        end
    end

    // Readies are forced low while reset is held, even though load_en is 1 then.
    assign s_aw_ready = rstn && load_en && grant_w;
    assign s_ar_ready = rstn && load_en && grant_r;
    assign aw_acc     = s_aw_valid && s_aw_ready;
    assign ar_acc     = s_ar_valid && s_ar_ready;

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            m_arw_valid <= 1'b0;
            m_arw_addr  <= '0;
            m_arw_id    <= '0;
            m_arw_len   <= '0;
            m_arw_size  <= '0;
            m_arw_burst <= '0;
            m_arw_lock  <= '0;
            m_arw_write <= 1'b0;
            last_grant  <= GRANT_READ;
        end else if (load_en) begin
            m_arw_valid <= aw_acc || ar_acc;
            if (aw_acc) begin
                m_arw_addr  <= s_aw_addr;
                m_arw_id    <= s_aw_id;
                m_arw_len   <= s_aw_len;
                m_arw_size  <= s_aw_size;
                m_arw_burst <= s_aw_burst;
                m_arw_lock  <= s_aw_lock;
                m_arw_write <= 1'b1;
                last_grant  <= GRANT_WRITE;
            end else if (ar_acc) begin
                m_arw_addr  <= s_ar_addr;
                m_arw_id    <= s_ar_id;
                m_arw_len   <= s_ar_len;
                m_arw_size  <= s_ar_size;
                m_arw_burst <= s_ar_burst;
                m_arw_lock  <= s_ar_lock;
                m_arw_write <= 1'b0;
                last_grant  <= GRANT_READ;
            end
        end
    end

    // W beats flow only while at least one issued write still owes its last beat.
    assign gate      = (wr_pending != 4'd0);
    assign m_w_valid = s_w_valid && gate;
    assign s_w_ready = m_w_ready && gate;
    assign m_w_id    = s_w_id;
    assign m_w_data  = s_w_data;
    assign m_w_strb  = s_w_strb;
    assign m_w_last  = s_w_last;
    assign w_done    = m_w_valid && m_w_ready && m_w_last;

    // Cannot wrap: increments are blocked at the limit, decrements need gate.
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            wr_pending <= 4'd0;
        end else if (aw_acc && !w_done) begin
            wr_pending <= wr_pending + 4'd1;
        end else if (w_done && !aw_acc) begin
            wr_pending <= wr_pending - 4'd1;
        end
    end

endmodule

// File: tb/tb_axi_arw_merger.sv
// Directed bench for axi_arw_merger: a vector table for arbitration, counting and
// W gating, plus hand-written reset sequences.
module tb_axi_arw_merger;

    logic         axi_clk = 1'b0;
    logic         rstn;
    logic         s_aw_valid, s_aw_ready;
    logic [31:0]  s_aw_addr;
    logic [7:0]   s_aw_id, s_aw_len;
    logic [2:0]   s_aw_size;
    logic [1:0]   s_aw_burst, s_aw_lock;
    logic         s_ar_valid, s_ar_ready;
    logic [31:0]  s_ar_addr;
    logic [7:0]   s_ar_id, s_ar_len;
    logic [2:0]   s_ar_size;
    logic [1:0]   s_ar_burst, s_ar_lock;
    logic         s_w_valid, s_w_ready;
    logic [7:0]   s_w_id;
    logic [127:0] s_w_data;
    logic [15:0]  s_w_strb;
    logic         s_w_last;
    logic         m_arw_valid, m_arw_ready;
    logic [31:0]  m_arw_addr;
    logic [7:0]   m_arw_id, m_arw_len;
    logic [2:0]   m_arw_size;
    logic [1:0]   m_arw_burst, m_arw_lock;
    logic         m_arw_write;
    logic         m_w_valid, m_w_ready;
    logic [7:0]   m_w_id;
    logic [127:0] m_w_data;
    logic [15:0]  m_w_strb;
    logic         m_w_last;
    logic [3:0]   wr_pending;

    int n_checks = 0;
    int n_fail   = 0;

    axi_arw_merger #(
        .ADDR_WIDTH(32), .ID_WIDTH(8), .DATA_WIDTH(128), .MAX_WR_PENDING(4)
    ) dut (
        .axi_clk(axi_clk), .rstn(rstn),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_aw_id(s_aw_id), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
        .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_id(s_ar_id), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_id(s_w_id),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .m_arw_valid(m_arw_valid), .m_arw_ready(m_arw_ready), .m_arw_addr(m_arw_addr),
        .m_arw_id(m_arw_id), .m_arw_len(m_arw_len), .m_arw_size(m_arw_size),
        .m_arw_burst(m_arw_burst), .m_arw_lock(m_arw_lock), .m_arw_write(m_arw_write),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_id(m_w_id),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .wr_pending(wr_pending)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic       aw, ar, ardy, wv, wl, wrdy;
        logic       e_awr, e_arr, e_swr, e_mwv;
        logic       e_av, e_wr;
        logic [3:0] e_pend;
        logic [31:0] e_addr;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        s_aw_valid = 0; s_ar_valid = 0; s_w_valid = 0; s_w_last = 0;
        m_arw_ready = 1; m_w_ready = 0;
    endtask

    // Payload for vector i: AW addr A000_0000|i len 3, AR addr 0010_0000|i len 63.
    task automatic drive_payload(input int i);
        s_aw_addr = 32'hA000_0000 | 32'(i); s_aw_id = 8'h80 | 8'(i); s_aw_len = 8'd3;
        s_aw_size = 3'd4; s_aw_burst = 2'd1; s_aw_lock = 2'd0;
        s_ar_addr = 32'h0010_0000 | 32'(i); s_ar_id = 8'd1; s_ar_len = 8'd63;
        s_ar_size = 3'd4; s_ar_burst = 2'd1; s_ar_lock = 2'd0;
        s_w_id = 8'h80 | 8'(i); s_w_strb = 16'hFFFF ^ 16'(i);
        s_w_data = {4{32'hD000_0000 + 32'(i)}};
    endtask

    initial begin
        //  aw ar ardy wv wl wrdy | awr arr swr mwv | av wr pend addr
        vecs[0]  = '{0,1,1,0,0,0, 0,1,0,0, 1,0,4'd0,32'h0010_0000};
        vecs[1]  = '{1,1,1,0,0,0, 1,0,0,0, 1,1,4'd1,32'hA000_0001};
        vecs[2]  = '{1,1,1,0,0,0, 0,1,0,0, 1,0,4'd1,32'h0010_0002};
        vecs[3]  = '{1,1,1,0,0,0, 1,0,0,0, 1,1,4'd2,32'hA000_0003};
        vecs[4]  = '{1,1,1,0,0,0, 0,1,0,0, 1,0,4'd2,32'h0010_0004};
        vecs[5]  = '{1,0,1,0,0,0, 1,0,0,0, 1,1,4'd3,32'hA000_0005};
        vecs[6]  = '{1,0,1,0,0,0, 1,0,0,0, 1,1,4'd4,32'hA000_0006};
        vecs[7]  = '{1,1,1,0,0,0, 0,1,0,0, 1,0,4'd4,32'h0010_0007};
        vecs[8]  = '{1,0,1,0,0,0, 0,0,0,0, 0,0,4'd4,32'h0};
        vecs[9]  = '{0,0,1,1,0,1, 0,0,1,1, 0,0,4'd4,32'h0};
        vecs[10] = '{0,0,1,1,1,1, 0,0,1,1, 0,0,4'd3,32'h0};
        vecs[11] = '{0,0,1,1,1,0, 0,0,0,1, 0,0,4'd3,32'h0};
        vecs[12] = '{0,1,0,0,0,0, 0,1,0,0, 1,0,4'd3,32'h0010_000C};
        vecs[13] = '{1,1,0,0,0,0, 0,0,0,0, 1,0,4'd3,32'h0010_000C};
        vecs[14] = '{1,1,0,0,0,0, 0,0,0,0, 1,0,4'd3,32'h0010_000C};
        vecs[15] = '{1,1,0,0,0,0, 0,0,0,0, 1,0,4'd3,32'h0010_000C};
        vecs[16] = '{1,0,1,0,0,0, 1,0,0,0, 1,1,4'd4,32'hA000_0010};
        vecs[17] = '{0,0,1,1,1,1, 0,0,1,1, 0,0,4'd3,32'h0};
        vecs[18] = '{0,0,1,1,1,1, 0,0,1,1, 0,0,4'd2,32'h0};
        vecs[19] = '{0,0,1,1,1,1, 0,0,1,1, 0,0,4'd1,32'h0};
        vecs[20] = '{0,0,1,1,0,1, 0,0,1,1, 0,0,4'd1,32'h0};
        vecs[21] = '{0,0,1,1,0,1, 0,0,1,1, 0,0,4'd1,32'h0};
        vecs[22] = '{0,0,1,1,0,1, 0,0,1,1, 0,0,4'd1,32'h0};
        vecs[23] = '{1,0,1,1,1,1, 1,0,1,1, 1,1,4'd1,32'hA000_0017};
        vecs[24] = '{0,0,1,1,1,1, 0,0,1,1, 0,0,4'd0,32'h0};
        vecs[25] = '{0,0,1,1,0,1, 0,0,0,0, 0,0,4'd0,32'h0};

        // Reset: readies must stay low even with valids asserted.
        drive_idle();
        drive_payload(0);
        rstn = 0;
        s_ar_valid = 1; s_aw_valid = 1; s_w_valid = 1; m_w_ready = 1;
        repeat (3) @(posedge axi_clk);
        #1;
        check("rst m_arw_valid", 128'(m_arw_valid), 128'(0));
        check("rst m_arw_addr",  128'(m_arw_addr),  128'(0));
        check("rst m_arw_write", 128'(m_arw_write), 128'(0));
        check("rst wr_pending",  128'(wr_pending),  128'(0));
        check("rst s_ar_ready",  128'(s_ar_ready),  128'(0));
        check("rst s_aw_ready",  128'(s_aw_ready),  128'(0));
        check("rst s_w_ready",   128'(s_w_ready),   128'(0));
        check("rst m_w_valid",   128'(m_w_valid),   128'(0));
        @(negedge axi_clk);
        drive_idle();
        rstn = 1;
        @(posedge axi_clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge axi_clk);
            drive_payload(i);
            s_aw_valid = vecs[i].aw; s_ar_valid = vecs[i].ar; m_arw_ready = vecs[i].ardy;
            s_w_valid = vecs[i].wv; s_w_last = vecs[i].wl; m_w_ready = vecs[i].wrdy;
            #1;
            check($sformatf("v%0d s_aw_ready", i), 128'(s_aw_ready), 128'(vecs[i].e_awr));
            check($sformatf("v%0d s_ar_ready", i), 128'(s_ar_ready), 128'(vecs[i].e_arr));
            check($sformatf("v%0d s_w_ready", i),  128'(s_w_ready),  128'(vecs[i].e_swr));
            check($sformatf("v%0d m_w_valid", i),  128'(m_w_valid),  128'(vecs[i].e_mwv));
            if (vecs[i].wv) begin
                check($sformatf("v%0d m_w_data", i), m_w_data, {4{32'hD000_0000 + 32'(i)}});
                check($sformatf("v%0d m_w_last", i), 128'(m_w_last), 128'(vecs[i].wl));
                check($sformatf("v%0d m_w_strb", i), 128'(m_w_strb), 128'(16'hFFFF ^ 16'(i)));
            end
            @(posedge axi_clk);
            #1;
            check($sformatf("v%0d m_arw_valid", i), 128'(m_arw_valid), 128'(vecs[i].e_av));
            check($sformatf("v%0d wr_pending", i),  128'(wr_pending),  128'(vecs[i].e_pend));
            if (vecs[i].e_av) begin
                check($sformatf("v%0d m_arw_write", i), 128'(m_arw_write), 128'(vecs[i].e_wr));
                check($sformatf("v%0d m_arw_addr", i),  128'(m_arw_addr),  128'(vecs[i].e_addr));
                check($sformatf("v%0d m_arw_len", i),   128'(m_arw_len),
                      128'(vecs[i].e_wr ? 8'd3 : 8'd63));
                check($sformatf("v%0d m_arw_id", i),    128'(m_arw_id),
                      128'(vecs[i].e_wr ? (8'h80 | vecs[i].e_addr[7:0]) : 8'd1));
            end
        end

        // Reset mid-burst: build two pending writes, hold a command, then drop rstn.
        @(negedge axi_clk);
        drive_idle();
        drive_payload(40);
        s_aw_valid = 1;
        @(posedge axi_clk);
        @(negedge axi_clk);
        @(posedge axi_clk);
        @(negedge axi_clk);
        s_aw_valid = 0; m_arw_ready = 0;
        s_w_valid = 1; s_w_last = 0; m_w_ready = 1;
        @(posedge axi_clk);
        #1;
        check("mid wr_pending before reset", 128'(wr_pending), 128'(2));
        check("mid m_arw_valid before reset", 128'(m_arw_valid), 128'(1));
        @(negedge axi_clk);
        rstn = 0;
        #1;
        check("mid rst wr_pending",  128'(wr_pending),  128'(0));
        check("mid rst m_arw_valid", 128'(m_arw_valid), 128'(0));
        check("mid rst m_arw_addr",  128'(m_arw_addr),  128'(0));
        check("mid rst m_w_valid",   128'(m_w_valid),   128'(0));
        check("mid rst s_w_ready",   128'(s_w_ready),   128'(0));
        @(negedge axi_clk);
        rstn = 1;
        @(posedge axi_clk);
        #1;
        check("post rst m_w_valid",  128'(m_w_valid),  128'(0));
        check("post rst wr_pending", 128'(wr_pending), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
